line_arbiter: RTL
=================

LINE_ARBITER -- requirements
Module: line_arbiter

Interface
REQ-001 Parameter DataWidth, default 8, sample width; each beat carries two samples {odd, even}.
REQ-002 Parameter LineWords, default 8, expected beats per line; used only by the length check.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 s0_valid_i / s0_ready_o / s0_sof_i / s0_eol_i  in/out/in/in  1 each  requester 0 stream handshake and framing.
REQ-006 s0_data_i  input  2*DataWidth  requester 0 beat; even sample in the low half.
REQ-007 s1_valid_i / s1_ready_o / s1_sof_i / s1_eol_i / s1_data_i  same as s0, requester 1.
REQ-008 m_ready_i / m_valid_o / m_sof_o / m_eol_o  in/out/out/out  1 each  stream to the shared border-expander/lifting pipeline.
REQ-009 m_data_o  output  2*DataWidth  granted beat.
REQ-010 m_id_o  output  1  source of the current m_ beat (0 or 1).
REQ-011 err_o  output  1  sticky line-length error flag.

Function
REQ-012 The block SHALL share one downstream stream between two requesters at whole-line granularity; a line never interleaves with the other requester.
REQ-013 FSM states SHALL be IDLE, GRANT0 and GRANT1.
REQ-014 IDLE: s0_ready_o=s1_ready_o=0; if any s*_valid_i is high, move to GRANTx next cycle; if both are high, grant the requester not served last (round-robin).
REQ-015 GRANTx: only sx_ready_o may be high; other ready=0.
REQ-016 GRANTx: return to IDLE the cycle after a beat with sx_eol_i=1 is accepted; exactly one bubble cycle between lines.
REQ-017 The output SHALL be a registered slice: sx_ready_o = grant & (!m_valid_o | m_ready_i); latency 1 cycle; full throughput within a line.
REQ-018 m_sof_o, m_eol_o, m_data_o and m_id_o SHALL be captured with the beat unchanged, and held stable while m_valid_o=1 and m_ready_i=0.
REQ-019 m_valid_o SHALL drop after handover when no new beat is accepted.
REQ-020 sof is passed through untouched; a grant begins on any beat, whether or not sof is set.
REQ-021 Accepting an eol beat and the downstream popping the previous beat in the same cycle SHALL both take effect.
REQ-022 last_served SHALL update when a line's eol beat is accepted.

Reset
REQ-023 On rst_i: state=IDLE, last_served=1 (s0 wins first tie), m_valid_o=0, m_sof_o=0, m_eol_o=0, m_data_o=0, m_id_o=0, err_o=0, both readies 0, beat counter 0.
REQ-024 Reset mid-line SHALL drop the in-flight line and any held output beat; no partial recovery.

Configuration
REQ-025 Macro LINE_ARBITER_LEN_CHECK_EN defined: count accepted beats per granted line; set err_o sticky if eol arrives on a beat index other than LineWords-1, or if LineWords beats pass without eol.
REQ-026 The count SHALL restart at each grant; a mismatch SHALL NOT change arbitration or data flow.
REQ-027 Macro LINE_ARBITER_LEN_CHECK_EN undefined: counter absent; err_o tied 0.

Structure
REQ-028 Shared package dwt97_pkg SHALL hold the arbiter state enum typedef and a stream beat struct {sof, eol, data}.
REQ-029 The output register stage SHALL be the sub-module stream_reg_slice; arbitration FSM stays in line_arbiter.

Verification
REQ-030 Only s0 sends 8 beats 0x0001..0x0008 (sof on first, eol on last), m_ready_i=1 -> m_ outputs 8 beats in order, m_id_o=0, first beat 2 cycles after s0_valid_i rises.
REQ-031 s0 and s1 both valid from reset, each sending 2 lines of 8 beats -> output line order s0,s1,s0,s1; no interleave; one bubble between lines.
REQ-032 Random m_ready_i and random sx_valid_i -> output data identical to input per source; no beat lost or duplicated; outputs stable while stalled.
REQ-033 rst_i pulsed after beat 4 of an s1 line -> m_valid_o=0 next cycle; next tie grants s0.
REQ-034 With LINE_ARBITER_LEN_CHECK_EN and LineWords=8, send a 6-beat line -> err_o=1 after eol beat and stays 1; data still forwarded.
REQ-035 Same 6-beat line without the macro -> err_o stays 0.

Source files
------------

// File: rtl/dwt97_pkg.sv
// Shared types for the line arbiter: arbitration state encoding and the
// default stream beat layout {sof, eol, data}.
package dwt97_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // Beat width of the default build: two 8-bit samples {odd, even}.
    localparam int unsigned DEF_BEAT_W = 16;

    typedef struct packed {
        logic                  sof;
        logic                  eol;
        logic [DEF_BEAT_W-1:0] data;
    } beat_t;

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry registered stream slice. The upstream side may load a new
// payload whenever the slot is empty or is being drained in the same cycle,
// giving full throughput with one cycle of latency. The held payload never
// changes while the slot is full and stalled.
module stream_reg_slice
    import dwt97_pkg::*;
#(
    parameter type payload_t = beat_t
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     up_valid,
    output logic     up_ready,
    input  payload_t up_payload,
    output logic     dn_valid,
    input  logic     dn_ready,
    output payload_t dn_payload
);

    assign up_ready = !dn_valid || dn_ready;

    // Load on an upstream transfer, otherwise empty the slot once it is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid   <= 1'b0;
            dn_payload <= '0;
        end else if (up_valid && up_ready) begin
            dn_valid   <= 1'b1;
            dn_payload <= up_payload;
        end else if (dn_ready) begin
            dn_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/line_arbiter.sv
// Two-requester line arbiter in front of the shared border-expander/lifting
// pipeline. Grants are held for a whole line (until the eol beat is accepted),
// ties are broken round-robin, and the granted beat goes through a registered
// slice. Optional macro LINE_ARBITER_LEN_CHECK_EN adds a per-line beat counter
// that raises a sticky err_o when a line is not exactly LineWords beats long.
//
// state  | meaning
// IDLE   | no grant, both readies low; picks the next requester
// GRANT0 | requester 0 owns the output until its eol beat is accepted
// GRANT1 | requester 1 owns the output until its eol beat is accepted
module line_arbiter
    import dwt97_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned LineWords = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s0_valid_i,
    output logic                   s0_ready_o,
    input  logic                   s0_sof_i,
    input  logic                   s0_eol_i,
    input  logic [2*DataWidth-1:0] s0_data_i,
    input  logic                   s1_valid_i,
    output logic                   s1_ready_o,
    input  logic                   s1_sof_i,
    input  logic                   s1_eol_i,
    input  logic [2*DataWidth-1:0] s1_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o,
    output logic                   m_id_o,
    output logic                   err_o
);

    typedef struct packed {
        logic                   sof;
        logic                   eol;
        logic [2*DataWidth-1:0] data;
    } line_beat_t;

    typedef struct packed {
        logic       id;
        line_beat_t beat;
    } slot_t;

    if (DataWidth == 0) begin : g_bad_data_width
        $error("line_arbiter: DataWidth must be at least 1");
    end
    if (LineWords == 0) begin : g_bad_line_words
        $error("line_arbiter: LineWords must be at least 1");
    end

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last_served;
    logic       slice_ready;
    logic       load;
    slot_t      slot_in;
    slot_t      slot_out;

    // Next-state, grant readies and the beat mux for the granted requester.
    always_comb begin
        state_nxt  = state;
        s0_ready_o = 1'b0;
        s1_ready_o = 1'b0;
        slot_in    = '0;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (s0_valid_i && s1_valid_i) begin
                    state_nxt = last_served ? GRANT0 : GRANT1;
                end else if (s0_valid_i) begin
                    state_nxt = GRANT0;
                end else if (s1_valid_i) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                s0_ready_o         = slice_ready;
                slot_in.id         = 1'b0;
                slot_in.beat.sof   = s0_sof_i;
                slot_in.beat.eol   = s0_eol_i;
                slot_in.beat.data  = s0_data_i;
                load               = s0_valid_i && slice_ready;
                if (load && s0_eol_i) begin
                    state_nxt = IDLE;
                end
            end
            GRANT1: begin
                s1_ready_o         = slice_ready;
                slot_in.id         = 1'b1;
                slot_in.beat.sof   = s1_sof_i;
                slot_in.beat.eol   = s1_eol_i;
                slot_in.beat.data  = s1_data_i;
                load               = s1_valid_i && slice_ready;
                if (load && s1_eol_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; the requester whose eol beat was just taken loses the next tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            state <= state_nxt;
            if (load && slot_in.beat.eol) begin
                last_served <= (state == GRANT1);
            end
        end
    end

    stream_reg_slice #(
        .payload_t (slot_t)
    ) u_out_slice (
        .clk        (clk_i),
        .rst        (rst_i),
        .up_valid   (load),
        .up_ready   (slice_ready),
        .up_payload (slot_in),
        .dn_valid   (m_valid_o),
        .dn_ready   (m_ready_i),
        .dn_payload (slot_out)
    );

    assign m_sof_o  = slot_out.beat.sof;
    assign m_eol_o  = slot_out.beat.eol;
    assign m_data_o = slot_out.beat.data;
    assign m_id_o   = slot_out.id;

`ifdef LINE_ARBITER_LEN_CHECK_EN
    // One extra count value lets the counter park at LineWords once a line overruns.
    localparam int unsigned     CntW    = $clog2(LineWords + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(LineWords - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(LineWords);

    logic [CntW-1:0] beat_cnt;
    logic            len_err;

    // Count accepted beats of the granted line; flag a short line or a missing eol.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else if (state == IDLE) begin
            beat_cnt <= '0;
        end else if (load) begin
            if (slot_in.beat.eol) begin
                if (beat_cnt != LastIdx) begin
                    len_err <= 1'b1;
                end
            end else if (beat_cnt >= LastIdx) begin
                len_err <= 1'b1;
            end
            if (beat_cnt != CntMax) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assign err_o = len_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
